// File: rtl/window_gen_3x3.sv
// rtl/window_gen_3x3.sv - streaming 3x3 window generator with two internal line buffers
module window_gen_3x3 #(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DATA_W-1:0] in_data,
    output logic              win_valid,
    output logic              win_last,
    output logic [DATA_W-1:0] px_1,
    output logic [DATA_W-1:0] px_2,
    output logic [DATA_W-1:0] px_3,
    output logic [DATA_W-1:0] px_4,
    output logic [DATA_W-1:0] px_5,
    output logic [DATA_W-1:0] px_6,
    output logic [DATA_W-1:0] px_7,
    output logic [DATA_W-1:0] px_8,
    output logic [DATA_W-1:0] px_9
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [DATA_W-1:0] sh_q [9];
    logic [DATA_W-1:0] sh_d [9];
    logic [DATA_W-1:0] px_q [9];
    logic [DATA_W-1:0] px_d [9];
    logic              win_valid_q, win_valid_d;
    logic              win_last_q, win_last_d;

    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb2 [IMG_W];

    logic              accept;
    logic              at_last;
    logic [CW-1:0]     pos_c;
    logic [RW-1:0]     pos_r;

    // A start-of-frame beat is always pixel (0,0), whatever the counters say.
    assign accept  = in_valid && (in_sof || (state_q == ACTIVE));
    assign pos_c   = in_sof ? '0 : col_q;
    assign pos_r   = in_sof ? '0 : row_q;
    assign at_last = (pos_r == ROW_LAST) && (pos_c == COL_LAST);

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sh_d        = sh_q;
        px_d        = px_q;
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
        if (accept) begin
            state_d = at_last ? IDLE : ACTIVE;
            if (at_last) begin
                col_d = '0;
                row_d = '0;
            end else if (pos_c == COL_LAST) begin
                col_d = '0;
                row_d = pos_r + RW'(1);
            end else begin
                col_d = pos_c + CW'(1);
                row_d = pos_r;
            end
            for (int i = 0; i < 3; i++) begin
                sh_d[3*i]   = sh_q[3*i+1];
                sh_d[3*i+1] = sh_q[3*i+2];
            end
            sh_d[2] = lb2[pos_c];
            sh_d[5] = lb1[pos_c];
            sh_d[8] = in_data;
            // Only interior positions publish; px outputs hold otherwise.
            if ((pos_r >= RW'(2)) && (pos_c >= CW'(2))) begin
                win_valid_d = 1'b1;
                win_last_d  = at_last;
                px_d        = sh_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                sh_q[i] <= '0;
                px_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_valid_q <= win_valid_d;
            win_last_q  <= win_last_d;
            sh_q        <= sh_d;
            px_q        <= px_d;
        end
    end

    // Line buffers need no reset; every frame rewrites rows before they are read.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[pos_c] <= lb1[pos_c];
            lb1[pos_c] <= in_data;
        end
    end

    assign win_valid = win_valid_q;
    assign win_last  = win_last_q;
    assign px_1      = px_q[0];
    assign px_2      = px_q[1];
    assign px_3      = px_q[2];
    assign px_4      = px_q[3];
    assign px_5      = px_q[4];
    assign px_6      = px_q[5];
    assign px_7      = px_q[6];
    assign px_8      = px_q[7];
    assign px_9      = px_q[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb/tb_window_gen_3x3.sv - table-driven check of window_gen_3x3 on a 5x4 frame
module tb_window_gen_3x3;

    localparam int W = 5;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       win_valid, win_last;
    logic [7:0] px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9;

    window_gen_3x3 #(.IMG_W(W), .IMG_H(H), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_valid(win_valid), .win_last(win_last),
        .px_1(px_1), .px_2(px_2), .px_3(px_3), .px_4(px_4), .px_5(px_5),
        .px_6(px_6), .px_7(px_7), .px_8(px_8), .px_9(px_9)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        last;
        logic [71:0] px;
    } win_t;

    win_t        exp_tab [6];
    win_t        got_q [$];
    int          got_cyc [$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          hold_viol = 0;
    int          gap_viol = 0;
    int          acc22 = -1;
    int          last_acc = 0;
    logic        prev_iv = 1'b0;
    logic [71:0] last_px = '0;
    logic [71:0] px_all;

    assign px_all = {px_1, px_2, px_3, px_4, px_5, px_6, px_7, px_8, px_9};

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_px = '0;
        end else if (win_valid) begin
            if (!prev_iv) gap_viol++;
            got_q.push_back({win_last, px_all});
            got_cyc.push_back(cyc);
            last_px = px_all;
        end else begin
            if (px_all !== last_px) hold_viol++;
            if (win_last !== 1'b0) hold_viol++;
        end
        prev_iv = in_valid;
    end

    task automatic chk(input string name, input logic [72:0] act, input logic [72:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic sof, input logic [7:0] d);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int off, input int maxgap);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                beat((r == 0) && (c == 0), 8'(off + 10*r + c));
                if ((r == 2) && (c == 2)) acc22 = last_acc;
                if (maxgap > 0) idle(int'($urandom_range(maxgap, 0)));
            end
        end
    endtask

    task automatic send_partial(input int off, input int nbeats);
        for (int i = 0; i < nbeats; i++)
            beat(i == 0, 8'(off + 10*(i / W) + (i % W)));
    endtask

    function automatic win_t add_off(input win_t w, input int off);
        win_t r;
        r = w;
        for (int k = 0; k < 9; k++) r.px[8*k +: 8] = w.px[8*k +: 8] + 8'(off);
        return r;
    endfunction

    task automatic check_frames(input string tag, input int off, input int nfr);
        int n;
        chk({tag, "_count"}, 73'(got_q.size()), 73'(6*nfr));
        n = (got_q.size() < 6*nfr) ? got_q.size() : 6*nfr;
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_win%0d", tag, i), got_q[i], add_off(exp_tab[i % 6], off));
        got_q.delete();
        got_cyc.delete();
    endtask

    initial begin
        exp_tab[0] = {1'b0, 8'd0,  8'd1,  8'd2,  8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22};
        exp_tab[1] = {1'b0, 8'd1,  8'd2,  8'd3,  8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23};
        exp_tab[2] = {1'b0, 8'd2,  8'd3,  8'd4,  8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24};
        exp_tab[3] = {1'b0, 8'd10, 8'd11, 8'd12, 8'd20, 8'd21, 8'd22, 8'd30, 8'd31, 8'd32};
        exp_tab[4] = {1'b0, 8'd11, 8'd12, 8'd13, 8'd21, 8'd22, 8'd23, 8'd31, 8'd32, 8'd33};
        exp_tab[5] = {1'b1, 8'd12, 8'd13, 8'd14, 8'd22, 8'd23, 8'd24, 8'd32, 8'd33, 8'd34};

        #12;
        chk("rst_valid", 73'(win_valid), 73'(0));
        chk("rst_last", 73'(win_last), 73'(0));
        chk("rst_px", 73'(px_all), 73'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // continuous frame, plus first-window latency
        send_frame(0, 0);
        idle(3);
        chk("latency", 73'(got_cyc.size() > 0 ? got_cyc[0] : -1), 73'(acc22));
        check_frames("cont", 0, 1);

        // random gaps between beats
        send_frame(0, 3);
        idle(3);
        check_frames("gaps", 0, 1);

        // beats without sof in IDLE are dropped
        for (int i = 0; i < 7; i++) beat(1'b0, 8'(200 + i));
        send_frame(0, 0);
        idle(3);
        check_frames("nosof", 0, 1);

        // abort frame A at (2,1) with frame B
        send_partial(0, 2*W + 1);
        send_frame(100, 0);
        idle(3);
        check_frames("abort", 100, 1);

        // asynchronous reset mid-row 3
        send_partial(0, 3*W + 3);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 73'(win_valid), 73'(0));
        chk("arst_px", 73'(px_all), 73'(0));
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        got_cyc.delete();
        send_frame(0, 0);
        idle(3);
        check_frames("postrst", 0, 1);

        // back-to-back frames
        send_frame(0, 0);
        send_frame(0, 0);
        idle(3);
        check_frames("b2b", 0, 2);

        chk("gap_valid", 73'(gap_viol), 73'(0));
        chk("px_hold", 73'(hold_viol), 73'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Streaming 3x3 window generator; sits directly upstream of the 3x3 median compare network.
- Accepts a raster-order pixel stream (one pixel per accepted beat, row-major, frame start flagged).
- Buffers two image lines internally and presents nine registered window pixels px_1..px_9 plus a valid strobe for every fully interior window.
- Output frame is (IMG_W-2) x (IMG_H-2) windows; no padding.

Parameters:
IMG_W, 64, pixels per line; legal range >= 3
IMG_H, 64, lines per frame; legal range >= 3
DATA_W, 8, pixel width in bits

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset; asynchronous and active-low
in_valid  input  1  in_data is valid this cycle; no backpressure, always accepted
in_sof  input  1  qualifies in_valid; marks pixel (0,0) of a frame
in_data  input  DATA_W  pixel value
win_valid  output  1  px_1..px_9 hold a complete window this cycle (single-cycle strobe)
win_last  output  1  with win_valid; last window of the frame
px_1..px_9  output  DATA_W each  window, row-major; px_1 top-left, px_5 centre, px_9 bottom-right

Behaviour:
- Reset (async, rst_n=0): win_valid=0, win_last=0, px_1..px_9=0, col=0, row=0, state=IDLE. Line buffer contents need not be cleared.
- States:
  - IDLE: beats with in_sof=0 are dropped. in_valid&in_sof: accept as pixel (0,0), go to ACTIVE.
  - ACTIVE: each in_valid beat is the next raster pixel. The column counter wraps IMG_W-1 -> 0 and increments row.
  - Accepting pixel (IMG_H-1, IMG_W-1) returns to IDLE.
  - in_valid&in_sof while ACTIVE aborts the current frame: the beat is taken as (0,0) of a new frame and the state stays ACTIVE. Windows of the aborted frame never complete.
- Line storage: two line buffers of depth IMG_W. On accepting pixel (r,c):
  - lb1[c] moves to lb2[c];
  - in_data is written to lb1[c].
  - Reading and writing the same address in the same cycle uses the old data.
- Window registers: a 3x3 shift array shifts left one column per accepted beat. The new right column is (lb2[c], lb1[c], in_data), i.e. rows r-2, r-1, r.
- Window validity: on accepting (r,c) with r>=2 and c>=2, the next cycle outputs the window with:
  - centre (r-1, c-1);
  - px_1=(r-2,c-2), px_2=(r-2,c-1), px_3=(r-2,c);
  - px_4=(r-1,c-2) ... px_9=(r,c).
- Latency: exactly 1 cycle from the accepting edge to win_valid=1.
- Non-output beats:
  - c<2 produces no window; windows never straddle a line wrap.
  - Rows 0 and 1 produce no windows.
  - Cycles with in_valid=0 give win_valid=0.
  - px outputs hold their last value while win_valid=0.
- win_last=1 only together with the window for accepted pixel (IMG_H-1, IMG_W-1).
- Gaps: any number of idle cycles between beats, including mid-line or at line wrap, do not change results.
- Back-to-back frames: in_sof is allowed in the cycle after the last pixel. That cycle's output is the previous frame's last window; the new frame starts cleanly.
- Reset mid-frame: immediate return to reset state. The next frame requires in_sof.
- Counters: col is $clog2(IMG_W) bits and row is $clog2(IMG_H) bits; no arithmetic overflow within legal parameter ranges.

Test Plan:
- IMG_W=5, IMG_H=4, pixel(r,c)=10r+c, continuous in_valid:
  - exactly 6 win_valid pulses;
  - first window comes 1 cycle after accepting pixel 22, with px_1..px_9 = 0,1,2,10,11,12,20,21,22;
  - last window has px_1=12, px_9=34 and win_last=1; win_last is 0 on all earlier windows.
- Same frame with random 0-3 idle cycles between beats -> identical 6 windows in order; win_valid never asserted during gap cycles.
- Stream 7 beats with in_sof=0 while IDLE, then the normal frame -> first 7 beats dropped; output identical to the first scenario.
- Abort: in_sof reasserted at pixel (2,1) of frame A, then full frame B (pixel=100+10r+c) -> no window containing frame-A data after the abort; first window is 100,101,102,110,...,122.
- rst_n pulsed low asynchronously (not clock-aligned) mid-row 3 -> outputs zero immediately; a following full frame with in_sof gives the first-scenario windows exactly.
- Two frames back-to-back, second in_sof in the cycle after pixel 34 -> 12 windows total; win_last pulses twice; the second frame's first window is correct.
